// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receive path: receiver state encodings,
// frame length and default inactivity timeout.
// Also holds the odd-parity helper used by the frame checker.
package ps2_rx_fifo_pkg;

  // Receiver sequencing through an 11-bit PS/2 frame
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  // cpu clk cycles without a falling edge before a partial frame is dropped
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  // PS/2 uses odd parity across the data byte and the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Purpose: small synchronous FIFO holding received scan codes.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push while full is refused unless a pop frees a slot that same cycle; pop when empty is ignored.
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when the indices match
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so stale storage never leaks out
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because dout is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// Purpose: PS/2 keyboard receiver (sync, glitch filter, frame FSM) feeding a scan-code FIFO; PS2_PARITY_CHECK_EN enables parity rejection.
// Latency: code/ready appear the cycle after the stop-bit falling edge is detected (FIFO empty).
// Backpressure: none towards the keyboard; a frame arriving with the FIFO full is dropped and sets sticky overflow.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          FILT_LEN   = 4,
  parameter logic [15:0] TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] code,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err,
  input  logic       clr
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  localparam int FW = $clog2(FILT_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic          filt_clk;
  logic          filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall_edge;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic [15:0]   tmo_cnt;

  logic          frame_good;
  logic          push_req;
  logic          fifo_full;
  logic          fifo_empty;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Two-flop synchronisers; pins idle high so reset to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: accept a new ps2_clk level only after FILT_LEN agreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall_edge = filt_prev && !filt_clk;

  // Stop bit must be high; parity only matters when checking is built in
  assign frame_good = data_s && (!PAR_CHECK || odd_parity_ok(shift_reg, par_bit));
  assign push_req   = fall_edge && (state == ST_STOP) && frame_good;

  // Frame receiver with inactivity timeout and sticky frame_err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      par_bit   <= 1'b0;
      tmo_cnt   <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      // Later set assignments override this, so a same-cycle error wins over clr
      if (clr) frame_err <= 1'b0;

      if (fall_edge || state == ST_IDLE) tmo_cnt <= 16'd0;
      else                               tmo_cnt <= tmo_cnt + 16'd1;

      if (fall_edge) begin
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_reg <= {data_s, shift_reg[7:1]};
            if (bit_cnt == 3'd7) state <= ST_PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: begin
            par_bit <= data_s;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!frame_good) frame_err <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && tmo_cnt >= TIMEOUT) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end
    end
  end

  // Sticky overflow: a good frame with no room, unless a pop frees a slot this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !rd) begin
      overflow <= 1'b1;
    end else if (clr) begin
      overflow <= 1'b0;
    end
  end

  ps2_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (rd),
    .din   (shift_reg),
    .dout  (code),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = !fifo_empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: stimulus queues expected scan codes,
// an independent monitor pops the FIFO and compares whenever ready is high.
// Direct checks cover reset values and the sticky flags.
module tb_ps2_rx_fifo;

  localparam int HALF = 10;
  localparam int TMO  = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] code;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         drain_en = 1'b0;

  ps2_rx_fifo #(
    .FIFO_DEPTH (4),
    .FILT_LEN   (4),
    .TIMEOUT    (16'(TMO))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd        (rd),
    .code      (code),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr       (clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: consumes one code per cycle while draining is enabled
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      rd = 1'b0;
      if (drain_en && ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%0h exp=none", code);
        end else begin
          e = exp_q.pop_front();
          if (code !== e) begin
            bad++;
            $display("FAIL sb_code got=%0h exp=%0h", code, e);
          end
        end
        rd = 1'b1;
      end
    end
  end

  // Drive the first nbits of an 11-bit frame, LSB first, data set up before each falling edge
  task automatic send_bits(input logic [7:0] d, input logic par, input int nbits);
    logic [10:0] f;
    f = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_raw(input logic [7:0] d, input logic par);
    send_bits(d, par, 11);
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_raw(d, ~^d);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  // Let the monitor empty the FIFO; a bounded wait that expires shows up as a failed check
  task automatic drain(input string name);
    int n;
    n = 0;
    drain_en = 1'b1;
    while ((exp_q.size() != 0 || ready !== 1'b0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_ready0"}, ready, 0);
    drain_en = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_code", code, 8'h00);
    check("rst_ready", ready, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame 0x1C
    exp_q.push_back(8'h1C);
    send_frame(8'h1C);
    #1;
    check("t1_ready", ready, 1);
    drain("t1");

    // Ordering: 0xF0 then 0x1C with no reads in between
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    #1;
    check("t2_head", code, 8'hF0);
    drain("t2");

    // Overflow: fifth frame dropped with depth 4
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    #1;
    check("t3_ovf", overflow, 1);
    check("t3_ferr", frame_err, 0);
    check("t3_head", code, 8'h01);
    pulse_clr();
    check("t3_ovf_clr", overflow, 0);
    drain("t3");

    // Parity error: 0x1C has three ones, parity bit 1 makes the total even
`ifdef PS2_PARITY_CHECK_EN
    send_raw(8'h1C, 1'b1);
    #1;
    check("t4_ferr", frame_err, 1);
    check("t4_ready", ready, 0);
    pulse_clr();
    check("t4_ferr_clr", frame_err, 0);
`else
    exp_q.push_back(8'h1C);
    send_raw(8'h1C, 1'b1);
    #1;
    check("t4_ferr", frame_err, 0);
    drain("t4");
`endif

    // Timeout: start + 5 data bits, then silence past TIMEOUT
    send_bits(8'hAA, 1'b1, 6);
    repeat (TMO + 40) @(negedge clk);
    #1;
    check("t5_ferr", frame_err, 1);
    check("t5_ready", ready, 0);
    pulse_clr();
    check("t5_ferr_clr", frame_err, 0);
    exp_q.push_back(8'h32);
    send_frame(8'h32);
    #1;
    check("t5_ferr_after", frame_err, 0);
    drain("t5");

    // Reset midway through data bit 4 with two codes queued
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11);
    send_frame(8'h22);
    #1;
    check("t6_queued", ready, 1);
    send_bits(8'h55, 1'b0, 5);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_code", code, 8'h00);
    check("t6_ready", ready, 0);
    check("t6_ovf", overflow, 0);
    check("t6_ferr", frame_err, 0);
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A);
    #1;
    check("t6_ready_new", ready, 1);
    check("t6_ferr_new", frame_err, 0);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
